// File: rtl/input_module.sv
// Memory-mapped input peripheral: debounces the "enter" button and queues the
// switch word per press in a small FIFO drained through data/status load ports.
module input_module #(
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_ADDR       = 1022,
  parameter int STATUS_ADDR     = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enter,
  input  logic [DATA_WIDTH-1:0] datain,
  input  logic [DATA_WIDTH-1:0] adress,
  input  logic                  MemRead,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  ready,
  output logic                  overflow
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int DCW = $clog2(DEBOUNCE_CYCLES);

  logic                             sync1_q, sync1_d, sync2_q, sync2_d;
  logic                             deb_q, deb_d;
  logic [DCW-1:0]                   cnt_q, cnt_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic [PW-1:0]                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             ready_q, ready_d;
  logic                             overflow_q, overflow_d;

  logic data_hit, status_hit, empty, full;
  logic push, pop, push_ok, drop;

  always_comb begin
    sync1_d = enter;
    sync2_d = sync1_q;
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    // deb only moves after DEBOUNCE_CYCLES consecutive disagreeing edges
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DCW'(1);
    end

    data_hit   = (adress == DATA_WIDTH'(DATA_ADDR));
    status_hit = (adress == DATA_WIDTH'(STATUS_ADDR));
    empty      = (count_q == '0);
    full       = (count_q == CW'(DEPTH));

    push    = deb_d & ~deb_q;
    pop     = MemRead & data_hit & ~empty;
    // a pop on the same edge frees the slot a full FIFO needs
    push_ok = push & (~full | pop);
    drop    = push & ~push_ok;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = datain;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (!push_ok && pop) count_d = count_q - CW'(1);
    ready_d = (count_d != '0);

    overflow_d = overflow_q;
    if (drop)                       overflow_d = 1'b1;
    else if (MemRead && status_hit) overflow_d = 1'b0;

    readdata = '0;
    if (data_hit && !empty) readdata = mem_q[rd_ptr_q];
    else if (status_hit)    readdata = DATA_WIDTH'({count_q, overflow_q, full, ready_q});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      cnt_q      <= '0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = ready_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_input_module.sv
// Scoreboard bench for input_module: stimulus queues expected load/probe
// results, a negedge monitor pops and compares them.
module tb_input_module;
  localparam int DW = 32;
  localparam logic [DW-1:0] DA = 32'd1022;
  localparam logic [DW-1:0] SA = 32'd1023;

  logic          clock, reset, enter, MemRead;
  logic [DW-1:0] datain, adress, readdata;
  logic          ready, overflow;
  logic          probe;

  typedef struct {
    logic [DW-1:0]   rd;
    logic            rdy;
    logic            ovf;
    logic [8*12-1:0] name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  input_module #(.DATA_WIDTH(DW), .DEPTH(4), .DEBOUNCE_CYCLES(4),
                 .DATA_ADDR(1022), .STATUS_ADDR(1023)) dut (
    .clock(clock), .reset(reset), .enter(enter), .datain(datain),
    .adress(adress), .MemRead(MemRead), .readdata(readdata),
    .ready(ready), .overflow(overflow));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: every cycle with a load or probe presented yields one check
  always @(negedge clock) begin
    if (MemRead || probe) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL scoreboard_empty: output seen with no expectation queued");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_chk++;
        if (readdata !== e.rd) begin
          n_fail++;
          $display("FAIL %0s readdata: got %h want %h", e.name, readdata, e.rd);
        end
        n_chk++;
        if (ready !== e.rdy) begin
          n_fail++;
          $display("FAIL %0s ready: got %b want %b", e.name, ready, e.rdy);
        end
        n_chk++;
        if (overflow !== e.ovf) begin
          n_fail++;
          $display("FAIL %0s overflow: got %b want %b", e.name, overflow, e.ovf);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // rd=1: CPU load; rd=0: passive probe of the combinational/registered outputs
  task automatic access(input logic rd, input logic [DW-1:0] addr,
                        input logic [DW-1:0] erd, input logic erdy,
                        input logic eovf, input logic [8*12-1:0] nm);
    exp_t e;
    e.rd = erd; e.rdy = erdy; e.ovf = eovf; e.name = nm;
    exp_q.push_back(e);
    adress = addr; MemRead = rd; probe = ~rd;
    tick();
    MemRead = 1'b0; probe = 1'b0; adress = '0;
  endtask

  task automatic press(input logic [DW-1:0] d);
    datain = d; enter = 1'b1;
    repeat (8) tick();
    enter = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; MemRead = 1'b0; probe = 1'b0;
    datain = '0; adress = '0;
    tick();
    access(0, SA, 32'h0, 0, 0, "in_reset");
    reset = 1'b0;
    tick();
    access(1, SA, 32'h0, 0, 0, "idle_status");

    // press latency: push on the 6th edge after enter is set (E0+5)
    datain = 32'hA5; enter = 1'b1;
    repeat (5) tick();
    access(0, SA, 32'h0, 0, 0, "pre_push");
    access(1, SA, 32'h09, 1, 0, "post_push");
    enter = 1'b0;
    access(1, DA, 32'hA5, 1, 0, "pop_a5");
    access(0, SA, 32'h0, 0, 0, "emptied");
    repeat (8) tick();

    // short glitch then long hold
    datain = 32'h3C; enter = 1'b1;
    repeat (3) tick();
    enter = 1'b0;
    repeat (8) tick();
    access(1, SA, 32'h0, 0, 0, "glitch");
    enter = 1'b1;
    repeat (10) tick();
    enter = 1'b0;
    repeat (8) tick();
    access(1, SA, 32'h09, 1, 0, "hold_once");
    access(1, DA, 32'h3C, 1, 0, "pop_3c");
    access(1, SA, 32'h0, 0, 0, "hold_empty");

    // five presses into a 4-deep FIFO
    for (int i = 1; i <= 5; i++) press(DW'(i));
    access(1, SA, 32'h27, 1, 1, "full_ovf");
    for (int i = 1; i <= 4; i++) access(1, DA, DW'(i), 1, 0, "drain");
    access(1, DA, 32'h0, 0, 0, "drain_empty");
    access(1, SA, 32'h0, 0, 0, "drain_stat");

    // full FIFO with a push landing on a data load
    for (int i = 0; i < 4; i++) press(32'h11 + DW'(i));
    access(1, SA, 32'h23, 1, 0, "full_noovf");
    datain = 32'h15; enter = 1'b1;
    repeat (5) tick();
    access(1, DA, 32'h11, 1, 0, "pop_on_push");
    access(1, SA, 32'h23, 1, 0, "still_full");
    enter = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) access(1, DA, 32'h12 + DW'(i), 1, 0, "drain2");
    access(0, SA, 32'h0, 0, 0, "drain2_end");

    // async reset with contents
    press(32'h77);
    press(32'h88);
    access(1, SA, 32'h11, 1, 0, "two_stored");
    #2 reset = 1'b1;
    access(0, SA, 32'h0, 0, 0, "async_rst");
    reset = 1'b0;
    tick();
    access(1, DA, 32'h0, 0, 0, "after_rst");

    repeat (2) tick();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left: %0d expectations unconsumed, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/input_module.md
# input_module

Memory-mapped user-input peripheral for the single-cycle MIPS datapath. It is the input-side counterpart of the output display module. It debounces a raw "enter" push-button and, on each press, captures the switch word into a small FIFO. The CPU drains the FIFO with ordinary load instructions at two fixed addresses: a data port and a status port. It sits beside data memory on the same address/MemRead bus; the top-level read mux selects its readdata when the address hits either port.

## Interface
Parameters:
- DATA_WIDTH, 32, width of switch word, address bus and readdata
- DEPTH, 4, FIFO entries; power of two, ≥2
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before the debounced level changes; ≥2
- DATA_ADDR, 1022, load address that returns and pops the FIFO head
- STATUS_ADDR, 1023, load address that returns status

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- enter  in  1  raw, asynchronous push-button level
- datain  in  DATA_WIDTH  switch word, sampled on the push cycle
- adress  in  DATA_WIDTH  CPU load/store address
- MemRead  in  1  CPU load strobe, valid for the whole cycle
- readdata  out  DATA_WIDTH  combinational read result
- ready  out  1  registered; high while FIFO is non-empty (drives LED)
- overflow  out  1  registered sticky flag: a press was dropped because the FIFO was full

## Operation
- Synchronizer: enter passes through two flops, sync1 then sync2.
- Debouncer: a registered level deb and a counter cnt.
  - If sync2 == deb, cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1, then deb <= sync2 and cnt <= 0; else cnt <= cnt+1.
  - Result: deb follows sync2 only after DEBOUNCE_CYCLES consecutive edges of disagreement; a glitch shorter than that is ignored.
- Push event: the edge on which deb transitions 0→1. The datain value present at that edge is written at wr_ptr. Release (deb 1→0) has no effect.
- Pop event: MemRead && adress == DATA_ADDR && FIFO non-empty, evaluated at the posedge; rd_ptr advances.
- Pointers: wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Full FIFO: a push is accepted only if count < DEPTH, or if a pop occurs on the same edge. Otherwise the word is dropped and overflow <= 1.
- Simultaneous push and pop: both take effect and count is unchanged. If the FIFO is empty, only the push happens; a pop on an empty FIFO is ignored.
- readdata, combinational:
  - adress == DATA_ADDR: the head entry, or 0 if empty.
  - adress == STATUS_ADDR: {zero-pad, count, overflow, full, ready}, with ready at bit0, full at bit1, overflow at bit2, count at bits [3+log2(DEPTH):3].
  - Any other address: 0. Output is independent of MemRead.
- Status read (MemRead && adress == STATUS_ADDR) clears overflow at that edge. A drop on the same edge takes priority, so overflow stays 1.
- Stores (no write port) never affect this block.

## Timing
- Reset values: sync1 = sync2 = deb = 0, cnt = 0, pointers = 0, count = 0, ready = 0, overflow = 0, FIFO storage = 0. readdata at STATUS_ADDR is 0 during reset.
- Press latency: enter rises before edge E0, so sync2 = 1 after edge E1. The push occurs at edge E1 + DEBOUNCE_CYCLES, and ready is high after that edge.
- Pop: the load sees the head in the same cycle (single-cycle CPU). The pointer advances at that cycle's posedge, and ready falls after the edge that empties the FIFO.
- Reset asserted mid-debounce or with FIFO contents discards everything. A button held through reset release produces a press only after a fresh debounce from deb = 0.

## Test plan
- Reset then idle. Required: ready = 0, overflow = 0, and a load from 1023 returns 0.
- DEBOUNCE_CYCLES = 4. Hold enter with datain = 0xA5 until the push.
  - Required: push exactly 5 edges after the first sampled high; ready = 1.
  - Load from 1022 returns 0xA5; after that edge ready = 0.
- Pulse enter for 3 cycles (shorter than 4).
  - Required: no push, count stays 0.
  - Also hold enter for 10 cycles: exactly one push, not repeated.
- Five presses (0x1..0x5) with no reads, DEPTH = 4.
  - Required: count = 4, full = 1, overflow = 1; the status word reads 0x27.
  - Four data loads return 0x1..0x4 in order, then 0.
  - The first status read clears overflow.
- FIFO full and a push coinciding with a data load.
  - Required: the load returns the old head, the new word is stored, count stays 4, and overflow stays 0.
- Two presses stored, then reset asserted asynchronously mid-cycle.
  - Required: ready drops immediately without a clock edge; after release, a load from 1022 returns 0.
